// File: rtl/mult_seq_hs_if.sv
// mult_seq_hs_if
//   Operand and product channels of the sequential multiplier.
//   Handshake rule for both channels: a transfer happens on a rising clk
//   edge where valid and ready are both high; the source holds valid and
//   its payload stable until that edge, and ready may not depend on the
//   same cycle's valid.
// Ports / signals:
//   in_valid, in_ready, in_a, in_b     operand channel (master -> slave)
//   out_valid, out_ready, out_data     product channel (slave -> master)
// Modports:
//   master  drives operands and out_ready (producer/consumer side)
//   slave   the multiplier itself
interface mult_seq_hs_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mult_seq_hs.sv
// mult_seq_hs
//   Iterative shift-add multiplier. Accepts one operand pair on the bus
//   operand channel, retires one multiplier bit per clock and presents the
//   full 2*WIDTH-bit product on the product channel until it is taken.
// Parameters:
//   WIDTH   operand width (2..32), product is 2*WIDTH bits
//   SIGNED  0: unsigned operands, 1: two's-complement operands and product
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        mult_seq_hs_if slave: in_valid/in_ready/in_a/in_b,
//              out_valid/out_ready/out_data
//   busy       high while a product is being computed or waiting to be taken
//   dbg_state  current FSM state (0 INIT, 1 IDLE, 2 CALC, 3 DONE)
// Build option:
//   MULT_EARLY_TERM_EN  when defined, CALC ends as soon as no set multiplier
//                       bits remain (minimum one step); results are unchanged.
module mult_seq_hs #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_seq_hs_if.slave      bus,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   sum;
    logic                 last_step;

    assign dbg_state = state;

    // Signed operands are multiplied as magnitudes; the most negative value
    // negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        mag_a  = bus.in_a;
        mag_b  = bus.in_b;
        neg_in = 1'b0;
        if (SIGNED) begin
            if (bus.in_a[WIDTH-1]) mag_a = -bus.in_a;
            if (bus.in_b[WIDTH-1]) mag_b = -bus.in_b;
            neg_in = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        end
    end

    // One partial product per step: multiplicand weighted by the bit index
    // of the multiplier LSB currently under inspection.
    always_comb begin
        partial = '0;
        if (mplier[0]) partial = {{WIDTH{1'b0}}, mcand} << cnt;
        sum = acc + partial;
`ifdef MULT_EARLY_TERM_EN
        // Finish once the bits still to be shifted in are all zero.
        last_step = (mplier[WIDTH-1:1] == '0);
`else
        last_step = (cnt == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                S_IDLE: begin
                    // in_ready is always high here, so in_valid alone is the accept.
                    if (bus.in_valid) begin
                        mcand        <= mag_a;
                        mplier       <= mag_b;
                        neg          <= neg_in;
                        acc          <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        bus.out_data  <= neg ? -sum : sum;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_hs.sv
// tb_mult_seq_hs
//   Drives an unsigned and a signed WIDTH=8 multiplier with the same
//   operand stream and checks each against an arithmetic reference model.
module tb_mult_seq_hs;
    localparam int W = 8;
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_ready = 1'b0;

    mult_seq_hs_if #(.WIDTH(W)) u_if ();
    mult_seq_hs_if #(.WIDTH(W)) s_if ();

    assign u_if.in_valid  = in_valid;
    assign u_if.in_a      = in_a;
    assign u_if.in_b      = in_b;
    assign u_if.out_ready = out_ready;
    assign s_if.in_valid  = in_valid;
    assign s_if.in_a      = in_a;
    assign s_if.in_b      = in_b;
    assign s_if.out_ready = out_ready;

    logic       busy_u, busy_s;
    logic [1:0] st_u, st_s;

    mult_seq_hs #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(u_if), .busy(busy_u), .dbg_state(st_u)
    );
    mult_seq_hs #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(s_if), .busy(busy_s), .dbg_state(st_s)
    );

    // index 0 = unsigned instance, index 1 = signed instance
    logic [1:0]     ov, ir, bz;
    logic [2*W-1:0] od [2];
    assign ov = {s_if.out_valid, u_if.out_valid};
    assign ir = {s_if.in_ready, u_if.in_ready};
    assign bz = {busy_s, busy_u};
    always_comb begin
        od[0] = u_if.out_data;
        od[1] = s_if.out_data;
    end

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q_u [$];
    logic [2*W-1:0] exp_q_s [$];
    logic [2*W-1:0] last_d [2];
    int checks = 0;
    int errors = 0;

    // Cycles from accept to out_valid for a multiplier magnitude.
    function automatic int exp_lat(input int magb);
        int l = 1;
        for (int i = 0; i < W; i++) if (magb[i]) l = i + 1;
        return EARLY ? l : W;
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int pu, ps, mu, ms, n;
        int lat [2];
        int seen [2];
        logic [2*W-1:0] e [2];
        logic [2*W-1:0] tmp;
        pu = int'(a) * int'(b);
        tmp = pu[2*W-1:0];
        exp_q_u.push_back(tmp);
        ps = int'($signed(a)) * int'($signed(b));
        tmp = ps[2*W-1:0];
        exp_q_s.push_back(tmp);
        mu = int'(b);
        ms = int'($signed(b));
        if (ms < 0) ms = -ms;
        lat[0] = exp_lat(mu);
        lat[1] = exp_lat(ms);
        seen[0] = -1; seen[1] = -1;
        e[0] = '0; e[1] = '0;

        n = 0;
        while (ir !== 2'b11 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ir !== 2'b11) begin
            errors++;
            $display("FAIL idle_wait: in_ready=%b required 11", ir);
        end

        in_a = a; in_b = b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        checks++;
        if (ir !== 2'b00 || bz !== 2'b11) begin
            errors++;
            $display("FAIL accept: in_ready=%b busy=%b required 00/11", ir, bz);
        end

        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (seen[i] < 0 && ov[i] === 1'b1) begin
                    seen[i] = k;
                    e[i] = (i == 0) ? exp_q_u.pop_front() : exp_q_s.pop_front();
                    last_d[i] = od[i];
                    checks++;
                    if (k != lat[i]) begin
                        errors++;
                        $display("FAIL latency[%0d] a=%h b=%h: got %0d required %0d", i, a, b, k, lat[i]);
                    end
                    checks++;
                    if (od[i] !== e[i]) begin
                        errors++;
                        $display("FAIL product[%0d] a=%h b=%h: got %h required %h", i, a, b, od[i], e[i]);
                    end
                end else if (hold == 0 && seen[i] >= 0 && k == seen[i] + 1) begin
                    checks++;
                    if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || bz[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL release[%0d]: valid=%b ready=%b busy=%b required 0/1/0", i, ov[i], ir[i], bz[i]);
                    end
                end
            end
            if (hold > 0 && seen[0] >= 0 && seen[1] >= 0) break;
            if (hold == 0 && seen[0] >= 0 && seen[1] >= 0 && k > seen[0] && k > seen[1]) break;
        end

        for (int i = 0; i < 2; i++) begin
            checks++;
            if (seen[i] < 0) begin
                errors++;
                $display("FAIL timeout[%0d] a=%h b=%h: no out_valid within %0d cycles", i, a, b, W + 2);
                if (i == 0) void'(exp_q_u.pop_front());
                else        void'(exp_q_s.pop_front());
            end
        end

        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (ov !== 2'b11 || ir !== 2'b00 || od[0] !== e[0] || od[1] !== e[1]) begin
                    errors++;
                    $display("FAIL hold: valid=%b ready=%b data=%h/%h required 11/00 %h/%h",
                             ov, ir, od[0], od[1], e[0], e[1]);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (ov !== 2'b00 || ir !== 2'b11) begin
                errors++;
                $display("FAIL hold_release: valid=%b ready=%b required 00/11", ov, ir);
            end
        end
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ir !== 2'b00 || ov !== 2'b00 || bz !== 2'b00 || od[0] !== '0 || od[1] !== '0 ||
                st_u !== 2'd0 || st_s !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: ready=%b valid=%b busy=%b data=%h/%h state=%0d/%0d required all 0",
                         ir, ov, bz, od[0], od[1], st_u, st_s);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 00 before first edge", ir);
        end
        @(negedge clk);
        checks++;
        if (ir !== 2'b11 || bz !== 2'b00) begin
            errors++;
            $display("FAIL reset_init: in_ready=%b busy=%b required 11/00", ir, bz);
        end
    endtask

    task automatic test_unsigned_max();
        do_txn(8'd255, 8'd255, 0);
        checks++;
        if (last_d[0] !== 16'hFE01 || last_d[1] !== 16'h0001) begin
            errors++;
            $display("FAIL max_255: got %h/%h required FE01/0001", last_d[0], last_d[1]);
        end
    endtask

    task automatic test_signed();
        do_txn(8'hFD, 8'h05, 0);
        checks++;
        if (last_d[1] !== 16'hFFF1) begin
            errors++;
            $display("FAIL signed_m3x5: got %h required FFF1", last_d[1]);
        end
        do_txn(8'h80, 8'h80, 0);
        checks++;
        if (last_d[1] !== 16'h4000) begin
            errors++;
            $display("FAIL signed_m128sq: got %h required 4000", last_d[1]);
        end
        do_txn(8'h7F, 8'h80, 0);
        checks++;
        if (last_d[1] !== 16'hC080) begin
            errors++;
            $display("FAIL signed_127xm128: got %h required C080", last_d[1]);
        end
    endtask

    task automatic test_backpressure();
        do_txn(8'd12, 8'd10, 5);
        checks++;
        if (last_d[0] !== 16'd120 || last_d[1] !== 16'd120) begin
            errors++;
            $display("FAIL backpressure: got %0d/%0d required 120", last_d[0], last_d[1]);
        end
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        @(negedge clk);
        checks++;
        if (ir !== 2'b11) begin
            errors++;
            $display("FAIL mid_idle: in_ready=%b required 11", ir);
        end
        in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ir !== 2'b00 || ov !== 2'b00 || bz !== 2'b00 || od[0] !== '0 || od[1] !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b busy=%b data=%h/%h required all 0",
                     ir, ov, bz, od[0], od[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (ov !== 2'b00) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL mid_discard: out_valid seen %0d cycles required 0", seen_valid);
        end
        out_ready = 1'b0;
        do_txn(8'd2, 8'd3, 0);
        checks++;
        if (last_d[0] !== 16'd6 || last_d[1] !== 16'd6) begin
            errors++;
            $display("FAIL mid_next: got %0d/%0d required 6", last_d[0], last_d[1]);
        end
    endtask

    task automatic test_latency();
        do_txn(8'h5A, 8'h01, 0);
        do_txn(8'h33, 8'h00, 0);
        checks++;
        if (last_d[0] !== '0 || last_d[1] !== '0) begin
            errors++;
            $display("FAIL zero_b: got %h/%h required 0", last_d[0], last_d[1]);
        end
        do_txn(8'h11, 8'h80, 0);
        do_txn(8'h00, 8'hC3, 1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 24; t++)
            do_txn(W'($urandom), W'($urandom), $urandom_range(0, 2));
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
